// File: rtl/snake_pkg.sv
// Shared snake game types: direction codes, run-state encoding, coordinate width.
// The button controller and renderer import this package too.
package snake_pkg;
  localparam int CW = 6;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_OVER   = 2'd3
  } run_state_e;

  // Opposite pairs differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
  function automatic dir_e opposite(input dir_e d);
    return dir_e'(d ^ 2'b01);
  endfunction
endpackage

// File: rtl/snake_tick_gen.sv
// Enable-gated modulo-TICK_DIV counter; tc is high while the count sits at TICK_DIV-1.
module snake_tick_gen #(
  parameter int TICK_DIV = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);
  localparam int CNTW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(TICK_DIV - 1);

  logic [CNTW-1:0] cnt_q;

  assign tc = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= tc ? '0 : cnt_q + CNTW'(1);
  end
endmodule

// File: rtl/snake_motion_engine.sv
// Snake game-step engine: advances the body one cell per tick, handles growth,
// wall/self collision, and answers registered cell-occupancy queries.
module snake_motion_engine #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int CW       = snake_pkg::CW,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int START_X  = 16,
  parameter int START_Y  = 12,
  parameter int TICK_DIV = 5000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    move_state,
  input  logic          is_paused,
  input  logic          start,
  input  logic [CW-1:0] food_x,
  input  logic [CW-1:0] food_y,
  input  logic          food_valid,
  input  logic [CW-1:0] query_x,
  input  logic [CW-1:0] query_y,
  output logic          query_hit,
  output logic [CW-1:0] head_x,
  output logic [CW-1:0] head_y,
  output logic [CW-1:0] snake_len,
  output logic          step,
  output logic          ate_food,
  output logic          game_over,
  output logic [1:0]    run_state
);
  import snake_pkg::*;

  run_state_e state_q, state_d;
  dir_e       dir_q, dir_d, new_dir;
  logic [MAX_LEN-1:0][CW-1:0] seg_x_q, seg_y_q, seg_x_d, seg_y_d;
  logic [CW-1:0] len_q, len_d, nx, ny, lim;
  logic step_q, step_d, ate_q, ate_d, hit_q, hit_d;
  logic tc, restart, wall, grow, self_hit;

  snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   ((state_q == ST_RUN) && !is_paused),
    .clr  (restart),
    .tc   (tc)
  );

  // Candidate move and collision evaluation, from the current body.
  always_comb begin
    new_dir = (dir_e'(move_state) == opposite(dir_q)) ? dir_q : dir_e'(move_state);
    nx   = seg_x_q[0];
    ny   = seg_y_q[0];
    wall = 1'b0;
    case (new_dir)
      DIR_UP:    begin wall = (seg_y_q[0] == '0);                ny = seg_y_q[0] - CW'(1); end
      DIR_DOWN:  begin wall = (seg_y_q[0] >= CW'(GRID_H - 1));   ny = seg_y_q[0] + CW'(1); end
      DIR_LEFT:  begin wall = (seg_x_q[0] == '0);                nx = seg_x_q[0] - CW'(1); end
      default:   begin wall = (seg_x_q[0] >= CW'(GRID_W - 1));   nx = seg_x_q[0] + CW'(1); end
    endcase
    grow = food_valid && (nx == food_x) && (ny == food_y);
    // Without growth the tail cell is vacated on this move, so it is not an obstacle.
    lim = grow ? len_q : len_q - CW'(1);
    self_hit = 1'b0;
    hit_d    = 1'b0;
    for (int j = 0; j < MAX_LEN; j++) begin
      if (CW'(j) < lim && seg_x_q[j] == nx && seg_y_q[j] == ny) self_hit = 1'b1;
      if (CW'(j) < len_q && seg_x_q[j] == query_x && seg_y_q[j] == query_y) hit_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    seg_x_d = seg_x_q;
    seg_y_d = seg_y_q;
    len_d   = len_q;
    step_d  = 1'b0;
    ate_d   = 1'b0;
    restart = 1'b0;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (is_paused) state_d = ST_PAUSED;
        else if (tc) begin
          if (wall || self_hit) state_d = ST_OVER;
          else begin
            seg_x_d[0] = nx;
            seg_y_d[0] = ny;
            for (int j = 1; j < MAX_LEN; j++) begin
              seg_x_d[j] = seg_x_q[j-1];
              seg_y_d[j] = seg_y_q[j-1];
            end
            dir_d  = new_dir;
            step_d = 1'b1;
            if (grow) begin
              ate_d = 1'b1;
              if (len_q < CW'(MAX_LEN)) len_d = len_q + CW'(1);
            end
          end
        end
      end
      ST_PAUSED: if (!is_paused) state_d = ST_RUN;
      default: begin
        if (start) begin
          restart = 1'b1;
          state_d = ST_RUN;
          dir_d   = DIR_RIGHT;
          len_d   = CW'(INIT_LEN);
          for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_d[i] = CW'(START_X - i);
            seg_y_d[i] = CW'(START_Y);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_RIGHT;
      len_q   <= CW'(INIT_LEN);
      step_q  <= 1'b0;
      ate_q   <= 1'b0;
      hit_q   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= CW'(START_X - i);
        seg_y_q[i] <= CW'(START_Y);
      end
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      len_q   <= len_d;
      step_q  <= step_d;
      ate_q   <= ate_d;
      hit_q   <= hit_d;
      seg_x_q <= seg_x_d;
      seg_y_q <= seg_y_d;
    end
  end

  assign query_hit = hit_q;
  assign head_x    = seg_x_q[0];
  assign head_y    = seg_y_q[0];
  assign snake_len = len_q;
  assign step      = step_q;
  assign ate_food  = ate_q;
  assign game_over = (state_q == ST_OVER);
  assign run_state = state_q;
endmodule

// File: tb/tb_snake_motion_engine.sv
// Directed bench for snake_motion_engine: a default-depth instance plus a
// MAX_LEN=4 instance sharing the same stimulus for saturation/tail cases.
module tb_snake_motion_engine;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    move_state;
  logic          is_paused, start, food_valid;
  logic [CW-1:0] food_x, food_y, query_x, query_y;

  logic          query_hit, step, ate_food, game_over;
  logic [CW-1:0] head_x, head_y, snake_len;
  logic [1:0]    run_state;

  logic          s_query_hit, s_step, s_ate_food, s_game_over;
  logic [CW-1:0] s_head_x, s_head_y, s_snake_len;
  logic [1:0]    s_run_state;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  snake_motion_engine #(.TICK_DIV(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .move_state(move_state), .is_paused(is_paused),
    .start(start), .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .query_x(query_x), .query_y(query_y), .query_hit(query_hit),
    .head_x(head_x), .head_y(head_y), .snake_len(snake_len), .step(step),
    .ate_food(ate_food), .game_over(game_over), .run_state(run_state)
  );

  snake_motion_engine #(.TICK_DIV(4), .MAX_LEN(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .move_state(move_state), .is_paused(is_paused),
    .start(start), .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .query_x(query_x), .query_y(query_y), .query_hit(s_query_hit),
    .head_x(s_head_x), .head_y(s_head_y), .snake_len(s_snake_len), .step(s_step),
    .ate_food(s_ate_food), .game_over(s_game_over), .run_state(s_run_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  // Advance until the next move edge (step or collision), bounded.
  task automatic wait_step(input string tag);
    int n = 0;
    do begin
      cyc(1);
      n++;
    end while (!step && !game_over && n < 8);
    chk(tag, 32'(step || game_over), 1);
  endtask

  initial begin
    rst_n = 1'b0; move_state = 2'd3; is_paused = 1'b0; start = 1'b0;
    food_valid = 1'b0; food_x = '0; food_y = '0; query_x = '0; query_y = '0;
    cyc(2);
    chk("rst_state", run_state, 0);
    chk("rst_head_x", head_x, 16);
    chk("rst_head_y", head_y, 12);
    chk("rst_len", snake_len, 3);
    chk("rst_step", step, 0);
    chk("rst_over", game_over, 0);
    chk("rst_hit", query_hit, 0);
    rst_n = 1'b1;

    // IDLE must not tick or move
    cyc(6);
    chk("idle_state", run_state, 0);
    chk("idle_head_x", head_x, 16);

    // First move exactly four cycles after start
    pulse_start();
    chk("start_run", run_state, 1);
    cyc(3);
    chk("pre_step", step, 0);
    cyc(1);
    chk("first_step", step, 1);
    chk("first_head_x", head_x, 17);
    chk("first_head_y", head_y, 12);
    chk("first_len", snake_len, 3);
    query_x = 6'd15; query_y = 6'd12;
    cyc(1);
    chk("query_tail", query_hit, 1);
    query_x = 6'd14;
    cyc(1);
    chk("query_dead", query_hit, 0);

    // Reversal rejected, then a legal turn
    move_state = 2'd2;
    wait_step("w_rev");
    chk("rev_head_x", head_x, 18);
    chk("rev_head_y", head_y, 12);
    move_state = 2'd0;
    wait_step("w_up");
    chk("up_head_x", head_x, 18);
    chk("up_head_y", head_y, 11);

    // Two eats; the MAX_LEN=4 instance saturates on the second
    food_valid = 1'b1; food_x = 6'd18; food_y = 6'd10;
    wait_step("w_eat1");
    chk("eat1_ate", ate_food, 1);
    chk("eat1_len", snake_len, 4);
    chk("eat1_head_y", head_y, 10);
    food_y = 6'd9;
    wait_step("w_eat2");
    chk("eat2_ate", ate_food, 1);
    chk("eat2_len", snake_len, 5);
    chk("sat_ate", s_ate_food, 1);
    chk("sat_len", s_snake_len, 4);
    food_valid = 1'b0;

    // Curl into own body: main (len 5) collides, sat (len 4) takes the vacating tail
    move_state = 2'd3;
    wait_step("w_r");
    chk("curl_r_x", head_x, 19);
    move_state = 2'd1;
    wait_step("w_d");
    chk("curl_d_y", head_y, 10);
    move_state = 2'd2;
    wait_step("w_self");
    chk("self_over", game_over, 1);
    chk("self_state", run_state, 3);
    chk("self_nostep", step, 0);
    chk("self_head_x", head_x, 19);
    chk("tail_step", s_step, 1);
    chk("tail_head_x", s_head_x, 18);
    chk("tail_head_y", s_head_y, 10);
    chk("tail_len", s_snake_len, 4);

    // Restart, run right into the wall
    move_state = 2'd3;
    pulse_start();
    chk("rs_head_x", head_x, 16);
    chk("rs_head_y", head_y, 12);
    chk("rs_len", snake_len, 3);
    chk("rs_state", run_state, 1);
    for (int i = 0; i < 15; i++) wait_step("w_right");
    chk("edge_head_x", head_x, 31);
    chk("edge_over", game_over, 0);
    wait_step("w_wall_r");
    chk("wall_r_over", game_over, 1);
    chk("wall_r_state", run_state, 3);
    chk("wall_r_x", head_x, 31);
    chk("wall_r_nostep", step, 0);
    is_paused = 1'b1;
    cyc(2);
    chk("over_ign_pause", run_state, 3);
    is_paused = 1'b0;

    // Restart, run up into the top wall (underflow)
    move_state = 2'd0;
    pulse_start();
    chk("rs2_state", run_state, 1);
    for (int i = 0; i < 12; i++) wait_step("w_upr");
    chk("top_head_y", head_y, 0);
    chk("top_head_x", head_x, 16);
    wait_step("w_wall_u");
    chk("wall_u_over", game_over, 1);
    chk("wall_u_y", head_y, 0);

    // Pause on the terminal-count cycle
    move_state = 2'd3;
    pulse_start();
    cyc(3);
    is_paused = 1'b1;
    cyc(1);
    chk("pause_nostep", step, 0);
    chk("pause_state", run_state, 2);
    chk("pause_head_x", head_x, 16);
    cyc(2);
    chk("pause_hold", step, 0);
    is_paused = 1'b0;
    cyc(1);
    chk("unpause_state", run_state, 1);
    chk("unpause_nostep", step, 0);
    cyc(1);
    chk("unpause_step", step, 1);
    chk("unpause_head_x", head_x, 17);
    pulse_start();
    chk("run_ign_start", run_state, 1);
    query_x = 6'd16; query_y = 6'd12;
    cyc(1);
    chk("query_body", query_hit, 1);
    query_x = 6'd15; query_y = 6'd11;
    query_x = 6'd15; query_y = 6'd11;
    cyc(1);
    chk("query_miss", query_hit, 0);
    query_x = 6'd17; query_y = 6'd12;
    cyc(1);

    // Asynchronous reset mid-run
    chk("pre_rst_hit", query_hit, 1);
    rst_n = 1'b0;
    #2;
    chk("arst_state", run_state, 0);
    chk("arst_head_x", head_x, 16);
    chk("arst_head_y", head_y, 12);
    chk("arst_len", snake_len, 3);
    chk("arst_hit", query_hit, 0);
    chk("arst_over", game_over, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
